// File: rtl/traffic_light_ctrl_if.sv
// Signal bundle between the intersection controller and its environment:
// detector/request inputs toward the controller, lamp drives and phase code back.
interface traffic_light_ctrl_if;
  logic       Sa;
  logic       Sb;
  logic       ped_req;
  logic       flash;
  logic       Ra, Ya, Ga;
  logic       Rb, Yb, Gb;
  logic       walk;
  logic [2:0] state;

  modport master (
    output Sa, Sb, ped_req, flash,
    input  Ra, Ya, Ga, Rb, Yb, Gb, walk, state
  );

  modport slave (
    input  Sa, Sb, ped_req, flash,
    output Ra, Ya, Ga, Rb, Yb, Gb, walk, state
  );
endinterface

// File: rtl/traffic_light_ctrl.sv
// Two-road intersection controller with pedestrian walk phase and flashing mode.
// Lamps are decoded purely from registered phase state, never from inputs.
module traffic_light_ctrl #(
  parameter int GREEN_MIN  = 6,
  parameter int GREEN_MAX  = 12,
  parameter int YELLOW_LEN = 2,
  parameter int ALLRED_LEN = 1,
  parameter int WALK_LEN   = 4,
  parameter int CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  traffic_light_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    A_GRN = 3'd0,
    A_YEL = 3'd1,
    AR_AB = 3'd2,
    B_GRN = 3'd3,
    B_YEL = 3'd4,
    AR_BA = 3'd5,
    WALK  = 3'd6,
    FLASH = 3'd7
  } phase_t;

  localparam logic [CNT_W-1:0] GMIN_M1 = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_M1 = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_M1  = CNT_W'(YELLOW_LEN - 1);
  localparam logic [CNT_W-1:0] AR_M1   = CNT_W'(ALLRED_LEN - 1);
  localparam logic [CNT_W-1:0] WALK_M1 = CNT_W'(WALK_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  phase_t           r_state;
  phase_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ped_pending;
  logic             r_dir;
  logic             r_flash_ph;
  logic             w_phase_chg;
  logic             w_walk_entry;

  // Phase register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= A_GRN;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-phase selection; flash overrides every normal transition
  always_comb begin
    w_next = r_state;
    if (bus.flash) begin
      w_next = FLASH;
    end else begin
      case (r_state)
        A_GRN: if (r_cnt >= GMIN_M1 && (bus.Sb || r_ped_pending)) w_next = A_YEL;
        A_YEL: if (r_cnt == YEL_M1) w_next = AR_AB;
        AR_AB: if (r_cnt == AR_M1) w_next = r_ped_pending ? WALK : B_GRN;
        B_GRN: if ((r_cnt >= GMIN_M1 && (bus.Sa || !bus.Sb || r_ped_pending)) ||
                   r_cnt == GMAX_M1) w_next = B_YEL;
        B_YEL: if (r_cnt == YEL_M1) w_next = AR_BA;
        AR_BA: if (r_cnt == AR_M1) w_next = r_ped_pending ? WALK : A_GRN;
        WALK:  if (r_cnt == WALK_M1) w_next = r_dir ? A_GRN : B_GRN;
        FLASH: w_next = AR_BA;
        default: w_next = A_GRN;
      endcase
    end
  end

  assign w_phase_chg  = (w_next != r_state);
  assign w_walk_entry = (w_next == WALK) && (r_state != WALK);

  // Phase timer, pedestrian latch, walk return direction and flash phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt         <= '0;
      r_ped_pending <= 1'b0;
      r_dir         <= 1'b0;
      r_flash_ph    <= 1'b0;
    end else begin
      if (w_phase_chg)           r_cnt <= '0;
      else if (r_cnt != CNT_SAT) r_cnt <= r_cnt + CNT_ONE;

      // Entering WALK wins over a request seen in the same cycle
      if (w_walk_entry)     r_ped_pending <= 1'b0;
      else if (bus.ped_req) r_ped_pending <= 1'b1;

      if (w_walk_entry) r_dir <= (r_state == AR_BA);

      if (w_next == FLASH) r_flash_ph <= (r_state == FLASH) ? ~r_flash_ph : 1'b1;
      else                 r_flash_ph <= 1'b0;
    end
  end

  // Moore lamp decode
  always_comb begin
    bus.Ra   = 1'b0;
    bus.Ya   = 1'b0;
    bus.Ga   = 1'b0;
    bus.Rb   = 1'b0;
    bus.Yb   = 1'b0;
    bus.Gb   = 1'b0;
    bus.walk = 1'b0;
    case (r_state)
      A_GRN: begin bus.Ga = 1'b1; bus.Rb = 1'b1; end
      A_YEL: begin bus.Ya = 1'b1; bus.Rb = 1'b1; end
      AR_AB, AR_BA: begin bus.Ra = 1'b1; bus.Rb = 1'b1; end
      B_GRN: begin bus.Ra = 1'b1; bus.Gb = 1'b1; end
      B_YEL: begin bus.Ra = 1'b1; bus.Yb = 1'b1; end
      WALK:  begin bus.Ra = 1'b1; bus.Rb = 1'b1; bus.walk = 1'b1; end
      FLASH: begin bus.Ya = r_flash_ph; bus.Yb = r_flash_ph; end
      default: ;
    endcase
  end

  assign bus.state = r_state;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl: phase sequences and lamp patterns
// checked cycle by cycle against hand-derived phase lengths (default parameters).
module tb_traffic_light_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  traffic_light_ctrl_if bus ();

  traffic_light_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Lamp vector order {Ra,Ya,Ga,Rb,Yb,Gb,walk}
  localparam logic [6:0] L_AGRN = 7'b0011000;
  localparam logic [6:0] L_AYEL = 7'b0101000;
  localparam logic [6:0] L_AR   = 7'b1001000;
  localparam logic [6:0] L_BGRN = 7'b1000010;
  localparam logic [6:0] L_BYEL = 7'b1000100;
  localparam logic [6:0] L_WALK = 7'b1001001;
  localparam logic [6:0] L_FL1  = 7'b0100100;
  localparam logic [6:0] L_FL0  = 7'b0000000;

  function automatic logic [6:0] lamps();
    return {bus.Ra, bus.Ya, bus.Ga, bus.Rb, bus.Yb, bus.Gb, bus.walk};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called at a falling edge; returns at the falling edge of cycle 0 after release
  task automatic reset_check();
    rst = 1'b1;
    #1;
    check_val("rst_state", 32'(bus.state), 32'd0);
    check_val("rst_lamps", 32'(lamps()), 32'(L_AGRN));
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic expect_phase(input string tag, input logic [2:0] st,
                              input logic [6:0] lp, input int n);
    for (int i = 0; i < n; i++) begin
      check_val({tag, "_state"}, 32'(bus.state), 32'(st));
      check_val({tag, "_lamps"}, 32'(lamps()), 32'(lp));
      @(negedge clk);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.Sa = 1'b0;
    bus.Sb = 1'b0;
    bus.ped_req = 1'b0;
    bus.flash = 1'b0;
    @(negedge clk);

    // Idle: no demand keeps A green
    reset_check();
    expect_phase("idle", 3'd0, L_AGRN, 30);

    // Sb demand, then B max-out, then Sa cuts B green at minimum
    reset_check();
    bus.Sb = 1'b1;
    expect_phase("sb_agrn", 3'd0, L_AGRN, 6);
    expect_phase("sb_ayel", 3'd1, L_AYEL, 2);
    expect_phase("sb_arab", 3'd2, L_AR, 1);
    expect_phase("maxout_bgrn", 3'd3, L_BGRN, 12);
    expect_phase("maxout_byel", 3'd4, L_BYEL, 2);
    expect_phase("maxout_arba", 3'd5, L_AR, 1);
    bus.Sa = 1'b1;
    expect_phase("sa_agrn", 3'd0, L_AGRN, 6);
    expect_phase("sa_ayel", 3'd1, L_AYEL, 2);
    expect_phase("sa_arab", 3'd2, L_AR, 1);
    expect_phase("sa_bgrn", 3'd3, L_BGRN, 6);
    expect_phase("sa_byel", 3'd4, L_BYEL, 2);
    expect_phase("sa_arba", 3'd5, L_AR, 1);
    expect_phase("sa_agrn2", 3'd0, L_AGRN, 1);
    bus.Sa = 1'b0;
    bus.Sb = 1'b0;

    // Pedestrian pulse in A green; request during WALK-entry cycle is ignored
    reset_check();
    expect_phase("ped_agrn", 3'd0, L_AGRN, 2);
    bus.ped_req = 1'b1;
    expect_phase("ped_agrn", 3'd0, L_AGRN, 1);
    bus.ped_req = 1'b0;
    expect_phase("ped_agrn", 3'd0, L_AGRN, 3);
    expect_phase("ped_ayel", 3'd1, L_AYEL, 2);
    bus.ped_req = 1'b1;
    expect_phase("ped_arab", 3'd2, L_AR, 1);
    bus.ped_req = 1'b0;
    expect_phase("ped_walk", 3'd6, L_WALK, 4);
    expect_phase("ped_bgrn", 3'd3, L_BGRN, 6);
    expect_phase("ped_byel", 3'd4, L_BYEL, 2);
    expect_phase("ped_arba", 3'd5, L_AR, 1);
    expect_phase("ped_clr_agrn", 3'd0, L_AGRN, 3);

    // Pedestrian pulse in B green: WALK from AR_BA returns to A green
    bus.Sb = 1'b1;
    expect_phase("pedb_agrn", 3'd0, L_AGRN, 3);
    expect_phase("pedb_ayel", 3'd1, L_AYEL, 2);
    expect_phase("pedb_arab", 3'd2, L_AR, 1);
    bus.ped_req = 1'b1;
    expect_phase("pedb_bgrn", 3'd3, L_BGRN, 1);
    bus.ped_req = 1'b0;
    expect_phase("pedb_bgrn", 3'd3, L_BGRN, 5);
    expect_phase("pedb_byel", 3'd4, L_BYEL, 2);
    expect_phase("pedb_arba", 3'd5, L_AR, 1);
    expect_phase("pedb_walk", 3'd6, L_WALK, 4);
    expect_phase("pedb_agrn2", 3'd0, L_AGRN, 6);
    expect_phase("pedb_ayel2", 3'd1, L_AYEL, 1);

    // Flash for 5 cycles in mid B green
    reset_check();
    bus.Sb = 1'b1;
    expect_phase("fl_agrn", 3'd0, L_AGRN, 6);
    expect_phase("fl_ayel", 3'd1, L_AYEL, 2);
    expect_phase("fl_arab", 3'd2, L_AR, 1);
    expect_phase("fl_bgrn", 3'd3, L_BGRN, 3);
    bus.flash = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check_val("flash_state", 32'(bus.state), 32'd7);
      check_val("flash_lamps", 32'(lamps()), (i % 2 == 0) ? 32'(L_FL1) : 32'(L_FL0));
      if (i == 4) bus.flash = 1'b0;
      @(negedge clk);
    end
    expect_phase("fl_arba", 3'd5, L_AR, 1);
    expect_phase("fl_agrn2", 3'd0, L_AGRN, 1);
    bus.Sb = 1'b0;

    // Reset in WALK with a fresh request pending: nothing survives
    reset_check();
    bus.ped_req = 1'b1;
    expect_phase("rw_agrn", 3'd0, L_AGRN, 1);
    bus.ped_req = 1'b0;
    expect_phase("rw_agrn", 3'd0, L_AGRN, 5);
    expect_phase("rw_ayel", 3'd1, L_AYEL, 2);
    expect_phase("rw_arab", 3'd2, L_AR, 1);
    expect_phase("rw_walk", 3'd6, L_WALK, 2);
    bus.ped_req = 1'b1;
    expect_phase("rw_walk", 3'd6, L_WALK, 1);
    bus.ped_req = 1'b0;
    reset_check();
    bus.Sb = 1'b1;
    expect_phase("post_rst_agrn", 3'd0, L_AGRN, 6);
    expect_phase("post_rst_ayel", 3'd1, L_AYEL, 2);
    expect_phase("post_rst_arab", 3'd2, L_AR, 1);
    expect_phase("post_rst_bgrn", 3'd3, L_BGRN, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/traffic_light_ctrl.md
TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

Interface
REQ-001 Parameter GREEN_MIN, default 6: minimum green length in cycles for either direction (>=1).
REQ-002 Parameter GREEN_MAX, default 12: B-direction green max-out length in cycles (>= GREEN_MIN).
REQ-003 Parameter YELLOW_LEN, default 2: yellow length in cycles (>=1).
REQ-004 Parameter ALLRED_LEN, default 1: all-red clearance length in cycles (>=1).
REQ-005 Parameter WALK_LEN, default 4: pedestrian walk length in cycles (>=1).
REQ-006 Parameter CNT_W, default 8: phase timer width; every length parameter SHALL be <= 2^CNT_W.
REQ-007 One clock; reset is asynchronous and active-high: clk  in  1  rising-edge clock.
REQ-008 rst  in  1  asynchronous active-high reset.
REQ-009 Sa  in  1  vehicle present on road A.
REQ-010 Sb  in  1  vehicle present on road B.
REQ-011 ped_req  in  1  pedestrian request, level or single-cycle pulse.
REQ-012 flash  in  1  fault/night mode request.
REQ-013 Ra, Ya, Ga  out  1 each  road A lamps.
REQ-014 Rb, Yb, Gb  out  1 each  road B lamps.
REQ-015 walk  out  1  pedestrian walk lamp.
REQ-016 state  out  3  current phase code.

Function
REQ-017 Phase codes SHALL be: A_GRN=0, A_YEL=1, AR_AB=2, B_GRN=3, B_YEL=4, AR_BA=5, WALK=6, FLASH=7.
REQ-018 Lamp outputs SHALL be Moore-decoded from registered state only, with no combinational path from any input.
REQ-019 Lamps per phase SHALL be: A_GRN Ga,Rb; A_YEL Ya,Rb; AR_AB/AR_BA Ra,Rb; B_GRN Ra,Gb; B_YEL Ra,Yb; WALK Ra,Rb,walk; FLASH Ya=Yb=flash_ph, all others 0; every unlisted lamp 0.
REQ-020 Timer cnt SHALL clear to 0 on every phase change and otherwise increment by 1 per cycle, saturating at 2^CNT_W-1.
REQ-021 ped_pending SHALL set on any cycle with ped_req=1 and clear on the cycle WALK is entered; ped_req asserted in the WALK-entry cycle SHALL NOT re-set it.
REQ-022 A_GRN -> A_YEL when cnt >= GREEN_MIN-1 and (Sb or ped_pending); otherwise hold, with no max-out.
REQ-023 B_GRN -> B_YEL when either: cnt >= GREEN_MIN-1 and (Sa or not Sb or ped_pending); or cnt == GREEN_MAX-1 (max-out).
REQ-024 Yellow phases SHALL last exactly YELLOW_LEN cycles: A_YEL -> AR_AB, B_YEL -> AR_BA.
REQ-025 AR phases SHALL last exactly ALLRED_LEN cycles, then go to WALK if ped_pending, else AR_AB -> B_GRN and AR_BA -> A_GRN.
REQ-026 WALK SHALL last exactly WALK_LEN cycles, then go to B_GRN if entered from AR_AB, or A_GRN if entered from AR_BA (1-bit dir register).
REQ-027 flash=1 SHALL force FLASH on the next clock from any phase, taking priority over all other transitions.
REQ-028 On FLASH entry flash_ph SHALL be set to 1, then toggle every cycle.
REQ-029 flash=0 while in FLASH SHALL go to AR_BA, which then follows REQ-025.
REQ-030 Ga and Gb SHALL never be 1 together, and no green SHALL follow the other direction's green without intervening yellow and all-red.

Reset
REQ-031 While rst=1, immediately (asynchronously): state=A_GRN, cnt=0, ped_pending=0, dir=0, flash_ph=0; outputs Ga=1, Rb=1, all other lamps 0, walk=0, state=0.
REQ-032 Reset mid-phase (including WALK or FLASH) SHALL discard the pending request and timer with no residual effect.

Verification (default parameters)
REQ-033 Reset, Sa=Sb=ped_req=flash=0 for 30 cycles -> state=0, Ga=Rb=1 throughout.
REQ-034 Sb=1 from first cycle after reset -> A_GRN cycles 0-5, A_YEL 6-7, AR_AB 8, B_GRN from cycle 9.
REQ-035 In B_GRN hold Sa=0, Sb=1 -> max-out: B_YEL entered after exactly 12 B_GRN cycles, then AR_BA 1 cycle, then A_GRN.
REQ-036 Pulse ped_req for 1 cycle at A_GRN cycle 2, Sb=0 -> A_YEL at cycle 6, AR_AB, then WALK 4 cycles (Ra=Rb=walk=1), then B_GRN; ped_pending=0 after WALK entry.
REQ-037 Assert flash mid B_GRN for 5 cycles -> state=7 next cycle, Ya=Yb sequence 1,0,1,0,1 with R/G lamps 0; on release -> AR_BA 1 cycle, then A_GRN.
REQ-038 Assert rst mid WALK -> walk=0, Ga=Rb=1, state=0 before the next clock edge; after release a fresh A_GRN minimum of 6 cycles applies.
